// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode values, FSM state
// encoding and the packed flag bundle.
package alu_mc_pkg;

    typedef logic [3:0] opcode_t;

    // Opcodes 0-7 match the original 3-bit accumulator ALU.
    localparam opcode_t OP_HLT  = 4'd0;
    localparam opcode_t OP_SKZ  = 4'd1;
    localparam opcode_t OP_ADD  = 4'd2;
    localparam opcode_t OP_AND  = 4'd3;
    localparam opcode_t OP_XOR  = 4'd4;
    localparam opcode_t OP_LDA  = 4'd5;
    localparam opcode_t OP_STO  = 4'd6;
    localparam opcode_t OP_JMP  = 4'd7;
    localparam opcode_t OP_SUB  = 4'd8;
    localparam opcode_t OP_OR   = 4'd9;
    localparam opcode_t OP_SHL  = 4'd10;
    localparam opcode_t OP_SHR  = 4'd11;
    localparam opcode_t OP_MUL  = 4'd12;
    localparam opcode_t OP_INC  = 4'd13;
    localparam opcode_t OP_DEC  = 4'd14;
    localparam opcode_t OP_RSVD = 4'd15;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus between the control FSM / accumulator and the ALU.
//   master: drives alu_ena, opcode, data (operand B), accum (operand A)
//   slave : drives ready, alu_out, done, zero and the four result flags
interface alu_mc_if
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic             alu_ena;
    opcode_t          opcode;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] accum;
    logic             ready;
    logic [WIDTH-1:0] alu_out;
    logic             done;
    logic             zero;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output alu_ena, opcode, data, accum,
        input  ready, alu_out, done, zero, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  alu_ena, opcode, data, accum,
        output ready, alu_out, done, zero, flag_n, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : capture a_i/b_i and begin (ignored semantics of busy are the caller's job)
//   a_i, b_i   : operands
//   busy_o     : a multiplication is in progress
//   product_o  : accumulated product including the current step (valid on the last step)
//   last_o     : current step is the final one
module alu_mc_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               last_o
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    always_comb begin
        product_o = acc_q + (b_q[0] ? a_q : '0);
        last_o    = (cnt_q == CW'(WIDTH - 1));
        busy_o    = busy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= {{WIDTH{1'b0}}, a_i};
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= product_o;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle accumulator ALU with registered result and N/Z/C/V flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of alu_mc_if (alu_ena/opcode/data/accum in;
//              ready/alu_out/done/zero/flag_* out)
// Every opcode except MUL completes on its accept edge; MUL runs WIDTH
// shift-add steps in alu_mc_mul_seq while ready is low.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    flags_t             flags_q, flags_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a, b;
    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     sum, shl_x, shr_x;
    logic [WIDTH-1:0]   sc_res;
    flags_t             sc_flags;

    logic               accept, mul_start, mul_busy, mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    assign a = bus.accum;
    assign b = bus.data;

    // Single-cycle datapath. The extra top bit of sum carries C (carry or
    // borrow); shl_x/shr_x keep the last shifted-out bit alongside the result.
    always_comb begin
        amt        = b[SHW-1:0];
        shl_x      = {1'b0, a} << amt;
        shr_x      = {a, 1'b0} >> amt;
        sum        = '0;
        sc_res     = a;
        sc_flags   = '0;
        unique case (bus.opcode)
            OP_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                sc_res     = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (a[MSB] == b[MSB]) && (sc_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum        = {1'b0, a} - {1'b0, b};
                sc_res     = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (a[MSB] != b[MSB]) && (sc_res[MSB] != a[MSB]);
            end
            OP_INC: begin
                sum        = {1'b0, a} + (WIDTH + 1)'(1);
                sc_res     = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = !a[MSB] && sc_res[MSB];
            end
            OP_DEC: begin
                sum        = {1'b0, a} - (WIDTH + 1)'(1);
                sc_res     = sum[WIDTH-1:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = a[MSB] && !sc_res[MSB];
            end
            OP_AND: sc_res = a & b;
            OP_XOR: sc_res = a ^ b;
            OP_OR:  sc_res = a | b;
            OP_LDA: sc_res = b;
            OP_SHL: begin
                sc_res     = shl_x[WIDTH-1:0];
                sc_flags.c = shl_x[WIDTH];
            end
            OP_SHR: begin
                sc_res     = shr_x[WIDTH:1];
                sc_flags.c = shr_x[0];
            end
            OP_RSVD: sc_flags.v = 1'b1;
            default: sc_res = a;  // HLT, SKZ, STO, JMP pass A; MUL handled by the FSM
        endcase
        sc_flags.n = sc_res[MSB];
        sc_flags.z = (sc_res == '0);
    end

    assign accept    = bus.alu_ena && (state_q == ST_IDLE);
    assign mul_start = accept && (bus.opcode == OP_MUL);

    alu_mc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (mul_busy),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.opcode == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        alu_out_d = sc_res;
                        flags_d   = sc_flags;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_busy && mul_last) begin
                    alu_out_d = mul_prod[WIDTH-1:0];
                    flags_d.n = mul_prod[MSB];
                    flags_d.z = (mul_prod[WIDTH-1:0] == '0);
                    flags_d.c = |mul_prod[2*WIDTH-1:WIDTH];
                    flags_d.v = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alu_out_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = (state_q == ST_IDLE);
    assign bus.alu_out = alu_out_q;
    assign bus.done    = done_q;
    assign bus.zero    = (bus.accum == '0);
    assign bus.flag_n  = flags_q.n;
    assign bus.flag_z  = flags_q.z;
    assign bus.flag_c  = flags_q.c;
    assign bus.flag_v  = flags_q.v;
endmodule
